flexdpe_out_collector: RTL and testbench

//  Downstream of the FLEX-DPE macro PE: captures each sparse output vector (per-PE valid + NUM_PES results).

---
 rtl/flexdpe_out_collector_pkg.sv | 23 ++
 rtl/flexdpe_out_collector_if.sv | 24 ++
 rtl/flexdpe_out_collector_lsb_prio_enc.sv | 30 +++
 rtl/flexdpe_out_collector.sv | 186 ++++++++++++++++++
 tb/tb_flexdpe_out_collector.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/flexdpe_out_collector_pkg.sv
// Shared definitions for the FLEX-DPE output collector: default widths,
// slot-count state encoding and a mask helper.
package flexdpe_pkg;

  localparam int OUT_DATA_TYPE = 24;
  localparam int NUM_PES       = 16;
  localparam int LOG2_PES      = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } slot_state_e;

  // Returns mask with bit idx cleared.
  function automatic logic [NUM_PES-1:0] clear_bit(input logic [NUM_PES-1:0] mask,
                                                    input logic [LOG2_PES-1:0] idx);
    logic [NUM_PES-1:0] sel;
    sel = {{(NUM_PES-1){1'b0}}, 1'b1} << idx;
    return mask & ~sel;
  endfunction

endpackage

// File: rtl/flexdpe_out_collector_if.sv
// Vector-in / word-out bundle of the FLEX-DPE output collector.
// master: producer + downstream consumer side; slave: collector side.
interface flexdpe_out_collector_if;
  import flexdpe_pkg::*;

  logic [NUM_PES-1:0]               i_data_valid;
  logic [NUM_PES*OUT_DATA_TYPE-1:0] i_data_bus;
  logic                             i_ready;
  logic                             o_valid;
  logic [OUT_DATA_TYPE-1:0]         o_data;
  logic [LOG2_PES-1:0]              o_pe_idx;
  logic                             o_last;

  modport master (
    output i_data_valid, i_data_bus, i_ready,
    input  o_valid, o_data, o_pe_idx, o_last
  );

  modport slave (
    input  i_data_valid, i_data_bus, i_ready,
    output o_valid, o_data, o_pe_idx, o_last
  );

endinterface

// File: rtl/flexdpe_out_collector_lsb_prio_enc.sv
// Lowest-set-bit priority encoder with "any bit set" and "exactly one bit set" flags.
module lsb_prio_enc
  import flexdpe_pkg::*;
#(
  parameter int N = NUM_PES,
  parameter int W = LOG2_PES
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         onehot
);

  localparam logic [N-1:0] ONE_C = {{(N-1){1'b0}}, 1'b1};

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
    any    = |vec;
    onehot = any && ((vec & (vec - ONE_C)) == {N{1'b0}});
  end

endmodule

// File: rtl/flexdpe_out_collector.sv
// FLEX-DPE output collector: captures sparse output vectors into a 2-slot
// buffer and serializes the valid results lowest PE index first.
// Optional feature macro: FLEXDPE_COLLECT_CNT_EN adds handshake/vector counters.
module flexdpe_out_collector
  import flexdpe_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  flexdpe_out_collector_if.slave    bus,
  output logic                      o_full,
  output logic                      o_overflow
`ifdef FLEXDPE_COLLECT_CNT_EN
  ,
  output logic [15:0]               o_result_cnt,
  output logic [15:0]               o_vec_cnt
`endif
);

  localparam int BUS_W = NUM_PES * OUT_DATA_TYPE;

  logic [NUM_PES-1:0]       slot_mask_r [2];
  logic [BUS_W-1:0]         slot_data_r [2];
  logic                     wr_ptr_r;
  logic                     rd_ptr_r;
  slot_state_e              state_r;
  logic                     o_valid_r;
  logic [OUT_DATA_TYPE-1:0] o_data_r;
  logic [LOG2_PES-1:0]      o_pe_idx_r;
  logic                     o_last_r;
  logic                     full_r;
  logic                     overflow_r;

  logic                     cap_req_s;
  logic                     pop_s;
  logic                     free_s;
  logic                     accept_s;
  logic                     drop_s;
  logic [NUM_PES-1:0]       nxt_mask_s [2];
  logic [BUS_W-1:0]         nxt_data_s [2];
  logic                     nxt_wr_ptr_s;
  logic                     nxt_rd_ptr_s;
  logic [NUM_PES-1:0]       head_mask_s;
  logic [BUS_W-1:0]         head_bus_s;
  logic [LOG2_PES-1:0]      head_idx_s;
  logic                     head_any_s;
  logic                     head_one_s;
  logic [OUT_DATA_TYPE-1:0] head_word_s;

  assign bus.o_valid  = o_valid_r;
  assign bus.o_data   = o_data_r;
  assign bus.o_pe_idx = o_pe_idx_r;
  assign bus.o_last   = o_last_r;
  assign o_full       = full_r;
  assign o_overflow   = overflow_r;

  // Handshake qualifiers; a full buffer only takes a vector when the head slot drains this cycle.
  always_comb begin
    cap_req_s = |bus.i_data_valid;
    pop_s     = o_valid_r && bus.i_ready;
    free_s    = pop_s && o_last_r;
    accept_s  = cap_req_s && ((state_r != ST_TWO) || free_s);
    drop_s    = cap_req_s && !accept_s;
  end

  // Next slot contents: pop clears first, so a capture into the slot being freed overwrites it.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      nxt_mask_s[s] = (pop_s && (rd_ptr_r == 1'(s))) ? clear_bit(slot_mask_r[s], o_pe_idx_r)
                                                     : slot_mask_r[s];
      nxt_mask_s[s] = (accept_s && (wr_ptr_r == 1'(s))) ? bus.i_data_valid : nxt_mask_s[s];
      nxt_data_s[s] = (accept_s && (wr_ptr_r == 1'(s))) ? bus.i_data_bus : slot_data_r[s];
    end
    nxt_wr_ptr_s = accept_s ? ~wr_ptr_r : wr_ptr_r;
    nxt_rd_ptr_s = free_s ? ~rd_ptr_r : rd_ptr_r;
    head_mask_s  = nxt_mask_s[nxt_rd_ptr_s];
  end

  lsb_prio_enc #(
    .N (NUM_PES),
    .W (LOG2_PES)
  ) u_enc (
    .vec    (head_mask_s),
    .idx    (head_idx_s),
    .any    (head_any_s),
    .onehot (head_one_s)
  );

  // Select the result word the next head index points at.
  always_comb begin
    head_bus_s  = nxt_data_s[nxt_rd_ptr_s];
    head_word_s = head_bus_s[head_idx_s*OUT_DATA_TYPE +: OUT_DATA_TYPE];
  end

  // Slot storage, pointers, slot-count FSM, overflow flag and registered output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        slot_mask_r[s] <= {NUM_PES{1'b0}};
        slot_data_r[s] <= {BUS_W{1'b0}};
      end
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      state_r    <= ST_EMPTY;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
      o_valid_r  <= 1'b0;
      o_data_r   <= {OUT_DATA_TYPE{1'b0}};
      o_pe_idx_r <= {LOG2_PES{1'b0}};
      o_last_r   <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        slot_mask_r[s] <= nxt_mask_s[s];
        slot_data_r[s] <= nxt_data_s[s];
      end
      wr_ptr_r <= nxt_wr_ptr_s;
      rd_ptr_r <= nxt_rd_ptr_s;
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_r <= ST_ONE;
          end else begin
            state_r <= ST_EMPTY;
          end
          full_r <= 1'b0;
        end
        ST_ONE: begin
          if (accept_s && !free_s) begin
            state_r <= ST_TWO;
            full_r  <= 1'b1;
          end else if (free_s && !accept_s) begin
            state_r <= ST_EMPTY;
            full_r  <= 1'b0;
          end else begin
            state_r <= ST_ONE;
            full_r  <= 1'b0;
          end
        end
        ST_TWO: begin
          if (free_s && !accept_s) begin
            state_r <= ST_ONE;
            full_r  <= 1'b0;
          end else begin
            state_r <= ST_TWO;
            full_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          full_r  <= 1'b0;
        end
      endcase
      overflow_r <= overflow_r | drop_s;
      o_valid_r  <= head_any_s;
      if (head_any_s) begin
        o_data_r   <= head_word_s;
        o_pe_idx_r <= head_idx_s;
        o_last_r   <= head_one_s;
      end else begin
        o_data_r   <= o_data_r;
        o_pe_idx_r <= o_pe_idx_r;
        o_last_r   <= o_last_r;
      end
    end
  end

`ifdef FLEXDPE_COLLECT_CNT_EN
  logic [15:0] result_cnt_r;
  logic [15:0] vec_cnt_r;

  assign o_result_cnt = result_cnt_r;
  assign o_vec_cnt    = vec_cnt_r;

  // Count accepted words and completed vectors; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_cnt_r <= 16'd0;
      vec_cnt_r    <= 16'd0;
    end else begin
      result_cnt_r <= result_cnt_r + {15'd0, pop_s};
      vec_cnt_r    <= vec_cnt_r + {15'd0, free_s};
    end
  end
`else
`endif

endmodule

// File: tb/tb_flexdpe_out_collector.sv
// Self-checking bench for flexdpe_out_collector: a queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_flexdpe_out_collector;
  import flexdpe_pkg::*;

  localparam int BW = NUM_PES * OUT_DATA_TYPE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic full;
  logic ovf;
`ifdef FLEXDPE_COLLECT_CNT_EN
  logic [15:0] rcnt;
  logic [15:0] vcnt;
`endif

  flexdpe_out_collector_if bus ();

  flexdpe_out_collector dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .o_full     (full),
    .o_overflow (ovf)
`ifdef FLEXDPE_COLLECT_CNT_EN
    ,
    .o_result_cnt (rcnt),
    .o_vec_cnt    (vcnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic cmp_en = 1'b0;

  // reference model state
  logic [NUM_PES-1:0] mq_mask [$];
  logic [BW-1:0]      mq_data [$];
  logic               ev = 1'b0, el = 1'b0, ef = 1'b0, eo = 1'b0;
  logic [23:0]        ed = 24'd0;
  logic [3:0]         ei = 4'd0;
  logic [15:0]        erc = 16'd0, evc = 16'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk(input int tag);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_PES; k++) v[k*OUT_DATA_TYPE +: OUT_DATA_TYPE] = 24'((tag << 8) | k);
    return v;
  endfunction

  // Reference model: FIFO of pending vectors, one word leaves per accepted handshake.
  initial begin
    int cnt0;
    logic done;
    logic [NUM_PES-1:0] m;
    logic found;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq_mask.delete(); mq_data.delete();
        ev = 0; el = 0; ef = 0; eo = 0; ed = 0; ei = 0; erc = 0; evc = 0;
      end else begin
        cnt0 = mq_mask.size();
        done = 1'b0;
        if (cnt0 > 0 && bus.i_ready) begin
          m = mq_mask[0];
          m = m & (m - 16'd1);
          erc++;
          if (m == 16'd0) begin
            void'(mq_mask.pop_front()); void'(mq_data.pop_front());
            done = 1'b1; evc++;
          end else mq_mask[0] = m;
        end
        if (|bus.i_data_valid) begin
          if (cnt0 < 2 || done) begin
            mq_mask.push_back(bus.i_data_valid); mq_data.push_back(bus.i_data_bus);
          end else eo = 1'b1;
        end
        if (mq_mask.size() > 0) begin
          ev = 1'b1; found = 1'b0;
          for (int k = 0; k < NUM_PES; k++) begin
            if (!found && mq_mask[0][k]) begin
              found = 1'b1; ei = 4'(k); ed = mq_data[0][k*OUT_DATA_TYPE +: OUT_DATA_TYPE];
            end
          end
          el = ($countones(mq_mask[0]) == 1);
        end else ev = 1'b0;
        ef = (mq_mask.size() == 2);
      end
    end
  end

  // Compare DUT against the model every cycle, mid-period.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_valid", 32'(bus.o_valid), 32'(ev));
      check("m_data", 32'(bus.o_data), 32'(ed));
      check("m_idx", 32'(bus.o_pe_idx), 32'(ei));
      check("m_last", 32'(bus.o_last), 32'(el));
      check("m_full", 32'(full), 32'(ef));
      check("m_ovf", 32'(ovf), 32'(eo));
`ifdef FLEXDPE_COLLECT_CNT_EN
      check("m_rcnt", 32'(rcnt), 32'(erc));
      check("m_vcnt", 32'(vcnt), 32'(evc));
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] dv, input int tag);
    bus.i_data_valid = dv; bus.i_data_bus = mk(tag);
    tick();
    bus.i_data_valid = 16'h0;
  endtask

  task automatic chk_word(input string nm, input logic v, input logic [3:0] idx,
                          input logic [23:0] d, input logic l);
    @(negedge clk);
    check({nm, "_valid"}, 32'(bus.o_valid), 32'(v));
    if (v) begin
      check({nm, "_idx"}, 32'(bus.o_pe_idx), 32'(idx));
      check({nm, "_data"}, 32'(bus.o_data), 32'(d));
      check({nm, "_last"}, 32'(bus.o_last), 32'(l));
    end
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_data", 32'(bus.o_data), 32'd0);
    check("rst_idx", 32'(bus.o_pe_idx), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
  endtask

  logic [15:0] pat [8];

  initial begin
    bus.i_data_valid = 16'h0; bus.i_data_bus = '0; bus.i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; cmp_en = 1'b1;
    @(negedge clk);
    check("init_valid", 32'(bus.o_valid), 32'd0);
    check("init_last", 32'(bus.o_last), 32'd0);
    check("init_full", 32'(full), 32'd0);
    check("init_ovf", 32'(ovf), 32'd0);

    // 1: single vector, four words lowest index first
    bus.i_ready = 1'b1;
    send(16'h8421, 1);
    chk_word("t1_w0", 1'b1, 4'd0, 24'h000100, 1'b0);
    chk_word("t1_w1", 1'b1, 4'd5, 24'h000105, 1'b0);
    chk_word("t1_w2", 1'b1, 4'd10, 24'h00010A, 1'b0);
    chk_word("t1_w3", 1'b1, 4'd15, 24'h00010F, 1'b1);
    chk_word("t1_end", 1'b0, 4'd0, 24'h0, 1'b0);
    check("t1_hold_idx", 32'(bus.o_pe_idx), 32'd15);

    // 2: backpressure holds the head word stable
    bus.i_ready = 1'b0;
    send(16'h0003, 2);
    for (int i = 0; i < 5; i++) chk_word("t2_hold", 1'b1, 4'd0, 24'h000200, 1'b0);
    bus.i_ready = 1'b1;
    chk_word("t2_w1", 1'b1, 4'd1, 24'h000201, 1'b1);
    chk_word("t2_end", 1'b0, 4'd0, 24'h0, 1'b0);

    // 3: third vector dropped while full
    tick();
    bus.i_ready = 1'b0;
    send(16'h0011, 3);
    send(16'h0300, 4);
    send(16'h1000, 5);
    @(negedge clk);
    check("t3_full", 32'(full), 32'd1);
    check("t3_ovf", 32'(ovf), 32'd1);
    bus.i_ready = 1'b1;
    chk_word("t3_w0", 1'b1, 4'd4, 24'h000304, 1'b1);
    chk_word("t3_w1", 1'b1, 4'd8, 24'h000408, 1'b0);
    chk_word("t3_w2", 1'b1, 4'd9, 24'h000409, 1'b1);
    chk_word("t3_end", 1'b0, 4'd0, 24'h0, 1'b0);
    check("t3_ovf_sticky", 32'(ovf), 32'd1);
    do_reset();

    // 4: capture in TWO accepted when the head's last word pops
    bus.i_ready = 1'b0;
    send(16'h0001, 6);
    send(16'h0006, 7);
    @(negedge clk);
    check("t4_full", 32'(full), 32'd1);
    check("t4_last", 32'(bus.o_last), 32'd1);
    bus.i_ready = 1'b1;
    send(16'h0020, 8);
    @(negedge clk);
    check("t4_full_kept", 32'(full), 32'd1);
    check("t4_no_ovf", 32'(ovf), 32'd0);
    check("t4_idx", 32'(bus.o_pe_idx), 32'd1);
    check("t4_data", 32'(bus.o_data), 32'h000701);
    chk_word("t4_w2", 1'b1, 4'd2, 24'h000702, 1'b1);
    chk_word("t4_w3", 1'b1, 4'd5, 24'h000805, 1'b1);
    check("t4_not_full", 32'(full), 32'd0);
    chk_word("t4_end", 1'b0, 4'd0, 24'h0, 1'b0);

    // 5: reset mid-vector
    send(16'hFFFF, 9);
    chk_word("t5_w0", 1'b1, 4'd0, 24'h000900, 1'b0);
    chk_word("t5_w1", 1'b1, 4'd1, 24'h000901, 1'b0);
    chk_word("t5_w2", 1'b1, 4'd2, 24'h000902, 1'b0);
    chk_word("t5_w3", 1'b1, 4'd3, 24'h000903, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid", 32'(bus.o_valid), 32'd0);
    check("t5_full", 32'(full), 32'd0);
    check("t5_ovf", 32'(ovf), 32'd0);
`ifdef FLEXDPE_COLLECT_CNT_EN
    check("t5_rcnt", 32'(rcnt), 32'd0);
    check("t5_vcnt", 32'(vcnt), 32'd0);
`endif

    // 6: back-to-back vectors of 3 and 5 results, no bubble between them
    send(16'h0007, 10);
    send(16'h001F, 11);
    chk_word("t6_w0", 1'b1, 4'd1, 24'h000A01, 1'b0);
    chk_word("t6_w1", 1'b1, 4'd2, 24'h000A02, 1'b1);
    chk_word("t6_w2", 1'b1, 4'd0, 24'h000B00, 1'b0);
    repeat (8) @(negedge clk);
    check("t6_drained", 32'(bus.o_valid), 32'd0);
`ifdef FLEXDPE_COLLECT_CNT_EN
    check("t6_rcnt", 32'(rcnt), 32'd8);
    check("t6_vcnt", 32'(vcnt), 32'd2);
`endif

    // mixed traffic with intermittent backpressure, checked by the model
    pat[0] = 16'h8001; pat[1] = 16'h0010; pat[2] = 16'h0700; pat[3] = 16'hC000;
    pat[4] = 16'h0042; pat[5] = 16'h0001; pat[6] = 16'h2222; pat[7] = 16'h0180;
    for (int i = 0; i < 32; i++) begin
      bus.i_data_valid = (i % 2 == 0) ? pat[(i/2) % 8] : 16'h0;
      bus.i_data_bus   = mk(32 + i);
      bus.i_ready      = (i % 5 != 4);
      tick();
    end
    bus.i_data_valid = 16'h0; bus.i_ready = 1'b1;
    repeat (40) tick();
    @(negedge clk);
    check("final_idle", 32'(bus.o_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
